control_seguimiento: RTL

Two-axis positioning controller for the pan/tilt tracker, next generation of the movement-control block. It drives the vertical (teta) and horizontal (fi) motor direction codes in either automatic mode (balancing paired light-sensor readings inside a deadband) or manual mode (reaching commanded angles by the shortest path around the circle, teta first, then fi). The block sits between the sensor/angle registers and the motor drivers. It adds a start/stop handshake, a settle filter, a done pulse, a timeout, and parametrised widths and limits.

---
 rtl/control_seguimiento_if.sv | 32 +++
 rtl/control_seguimiento.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/control_seguimiento_if.sv
// Handshake and data bundle between the tracker register block and control_seguimiento.
interface control_seguimiento_if #(
  parameter int W = 16
);
  logic         start;
  logic         stop;
  logic         modo;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] C;
  logic [W-1:0] D;
  logic [W-1:0] teta_d;
  logic [W-1:0] fi_d;
  logic [W-1:0] teta_actual;
  logic [W-1:0] fi_actual;
  logic [1:0]   S_out_teta;
  logic [1:0]   S_out_fi;
  logic         busy;
  logic         done;
  logic         timeout;
  logic         err;

  modport master (
    output start, stop, modo, A, B, C, D, teta_d, fi_d, teta_actual, fi_actual,
    input  S_out_teta, S_out_fi, busy, done, timeout, err
  );

  modport slave (
    input  start, stop, modo, A, B, C, D, teta_d, fi_d, teta_actual, fi_actual,
    output S_out_teta, S_out_fi, busy, done, timeout, err
  );
endinterface

// File: rtl/control_seguimiento.sv
// Pan/tilt positioning controller: automatic sensor balancing or manual shortest-path
// angle seeking (teta then fi), with settle filter, timeout and start/stop handshake.
module control_seguimiento #(
  parameter int W           = 16,
  parameter int ANGLE_MAX   = 360,
  parameter int ERR         = 2,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  control_seguimiento_if.slave  bus
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W:0]    AMAX        = (W+1)'(ANGLE_MAX);
  localparam logic [W:0]    AHALF       = (W+1)'(ANGLE_MAX / 2);
  localparam logic [W:0]    ERRV        = (W+1)'(ERR);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYC);
  localparam logic [TW-1:0] TOUT_LAST   = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    AUTO   = 3'd1,
    M_TETA = 3'd2,
    M_FI   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Returns {in_band, code}; x<y pulls the axis down (01), x>y pushes it up (10).
  function automatic logic [2:0] auto_eval(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] xe;
    logic [W:0] ye;
    logic [2:0] r;
    xe = {1'b0, x};
    ye = {1'b0, y};
    if ((xe <= ye + ERRV) && (ye <= xe + ERRV)) r = 3'b100;
    else if (xe < ye)                             r = 3'b001;
    else                                          r = 3'b010;
    return r;
  endfunction

  // Shortest path around the circle; an exact half turn resolves to increase.
  function automatic logic [2:0] man_eval(input logic [W-1:0] tgt, input logic [W-1:0] act);
    logic [W:0] te;
    logic [W:0] ae_raw;
    logic [W:0] ae;
    logic [W:0] diff;
    logic [W:0] rev;
    logic [2:0] r;
    te     = {1'b0, tgt};
    ae_raw = {1'b0, act};
    ae     = (ae_raw >= AMAX) ? ae_raw - AMAX : ae_raw;
    diff   = (te >= ae) ? te - ae : te + AMAX - ae;
    rev    = AMAX - diff;
    if ((diff <= ERRV) || (rev <= ERRV)) r = 3'b100;
    else if (diff <= AHALF)              r = 3'b010;
    else                                 r = 3'b001;
    return r;
  endfunction

  state_t        state, next_state;
  logic [SW-1:0] settle_cnt, next_settle, settle_cand;
  logic [TW-1:0] tout_cnt, next_tout;
  logic [W-1:0]  teta_tgt, fi_tgt;
  logic [1:0]    out_teta, out_fi, next_teta, next_fi;
  logic          busy_flag, done_flag, timeout_flag, err_flag;
  logic          next_done, next_timeout, next_err;
  logic          latch, band, active, targets_ok;
  logic [2:0]    auto_fi, auto_teta, man_teta, man_fi;

  assign auto_fi    = auto_eval(bus.A, bus.B);
  assign auto_teta  = auto_eval(bus.C, bus.D);
  assign man_teta   = man_eval(teta_tgt, bus.teta_actual);
  assign man_fi     = man_eval(fi_tgt, bus.fi_actual);
  assign targets_ok = ({1'b0, bus.teta_d} < AMAX) && ({1'b0, bus.fi_d} < AMAX);
  assign active     = (state == AUTO) || (state == M_TETA) || (state == M_FI);

  // Next-state, counter and output decode.
  always_comb begin
    next_state   = state;
    next_teta    = 2'b00;
    next_fi      = 2'b00;
    next_done    = 1'b0;
    next_timeout = 1'b0;
    next_err     = 1'b0;
    next_tout    = tout_cnt;
    settle_cand  = '0;
    latch        = 1'b0;
    band         = 1'b0;

    case (state)
      IDLE: begin
        next_tout = '0;
        if (bus.stop || !bus.start) begin
          next_state = IDLE;
        end else if (!bus.modo) begin
          next_state = AUTO;
        end else if (targets_ok) begin
          next_state = M_TETA;
          latch      = 1'b1;
        end else begin
          next_err = 1'b1;
        end
      end
      AUTO: begin
        band      = auto_fi[2] & auto_teta[2];
        next_teta = auto_teta[1:0];
        next_fi   = auto_fi[1:0];
      end
      M_TETA: begin
        band      = man_teta[2];
        next_teta = man_teta[1:0];
      end
      M_FI: begin
        band    = man_fi[2];
        next_fi = man_fi[1:0];
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase

    // Abort paths win over settle completion: stop first, then timeout.
    if (active) begin
      next_tout = tout_cnt + TW'(1);
      if (band) settle_cand = (settle_cnt == SETTLE_MAX) ? settle_cnt : settle_cnt + SW'(1);
      else      settle_cand = '0;
      if (bus.stop) begin
        next_state = IDLE;
        next_teta  = 2'b00;
        next_fi    = 2'b00;
      end else if (tout_cnt == TOUT_LAST) begin
        next_state   = IDLE;
        next_timeout = 1'b1;
        next_teta    = 2'b00;
        next_fi      = 2'b00;
      end else if (band && (settle_cnt >= SETTLE_LAST)) begin
        next_state = (state == M_TETA) ? M_FI : DONE;
        next_done  = (state != M_TETA);
        next_teta  = 2'b00;
        next_fi    = 2'b00;
      end else begin
        next_state = state;
      end
    end else begin
      settle_cand = '0;
    end

    next_settle = (next_state != state) ? '0 : settle_cand;
  end

  // State, counters, latched targets and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      settle_cnt   <= '0;
      tout_cnt     <= '0;
      teta_tgt     <= '0;
      fi_tgt       <= '0;
      out_teta     <= 2'b00;
      out_fi       <= 2'b00;
      busy_flag    <= 1'b0;
      done_flag    <= 1'b0;
      timeout_flag <= 1'b0;
      err_flag     <= 1'b0;
    end else begin
      state        <= next_state;
      settle_cnt   <= next_settle;
      tout_cnt     <= next_tout;
      teta_tgt     <= latch ? bus.teta_d : teta_tgt;
      fi_tgt       <= latch ? bus.fi_d : fi_tgt;
      out_teta     <= next_teta;
      out_fi       <= next_fi;
      busy_flag    <= (next_state != IDLE);
      done_flag    <= next_done;
      timeout_flag <= next_timeout;
      err_flag     <= next_err;
    end
  end

  assign bus.S_out_teta = out_teta;
  assign bus.S_out_fi   = out_fi;
  assign bus.busy       = busy_flag;
  assign bus.done       = done_flag;
  assign bus.timeout    = timeout_flag;
  assign bus.err        = err_flag;

endmodule
